// File: rtl/gpio_cmd_ctrl.sv
// GPIO command decoder/sequencer for the convolution datapath: kernel and length
// loading, circular column-memory writes, convolver start and result read-back.
module gpio_cmd_ctrl #(
    parameter int N      = 2,
    parameter int ADDR_W = 10,
    parameter int PIX_W  = 8,
    parameter int RES_W  = 13,
    parameter int GPIO_D = 32
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic [GPIO_D-1:0]    i_gpio,
    output logic [GPIO_D-1:0]    o_gpio,
    output logic                 o_led,
    output logic [71:0]          o_kernel,
    output logic                 o_kernel_valid,
    output logic [ADDR_W-1:0]    o_img_len,
    output logic [N+1:0]         o_mem_we,
    output logic [ADDR_W-1:0]    o_mem_addr,
    output logic [PIX_W-1:0]     o_mem_wdata,
    output logic                 o_start,
    input  logic                 i_conv_done,
    output logic [$clog2(N)-1:0] o_rd_sel,
    output logic [ADDR_W-1:0]    o_rd_addr,
    input  logic [RES_W-1:0]     i_rd_data
);
    localparam int WS_W = $clog2(N+2);
    localparam int RS_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, READY, READ} state_t;

    state_t              state_q, state_d;
    logic                valid_prev_q, valid_prev_d;
    logic [2:0]          ctrl_prev_q, ctrl_prev_d;
    logic [1:0]          krow_q, krow_d;
    logic [2:0][23:0]    kernel_q, kernel_d;
    logic                kvalid_q, kvalid_d;
    logic [ADDR_W-1:0]   img_len_q, img_len_d;
    logic [WS_W-1:0]     wsel_q, wsel_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [N+1:0]        we_q, we_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [PIX_W-1:0]    wdata_q, wdata_d;
    logic                start_pend_q, start_pend_d;
    logic                start_q, start_d;
    logic                led_q, led_d;
    logic [RS_W-1:0]     rsel_q, rsel_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [RES_W-1:0]    rdata_q, rdata_d;

    logic [2:0]  ctrl;
    logic [23:0] data;
    logic        soft_rst;
    logic        evt;
    logic [1:0]  krow_eff;
    logic        do_cmd;
    logic        unused_gpio_bits;

    assign ctrl             = i_gpio[31:29];
    assign data             = i_gpio[24:1];
    assign soft_rst         = i_gpio[0];
    assign evt              = i_gpio[28] & ~valid_prev_q;
    assign unused_gpio_bits = ^i_gpio[27:25];
    // Switching onto the kernel-load command restarts at row 0 in that same cycle.
    assign krow_eff         = (ctrl_prev_q != 3'b000) ? 2'd0 : krow_q;

    always_comb begin
        state_d      = state_q;
        valid_prev_d = i_gpio[28];
        ctrl_prev_d  = ctrl;
        krow_d       = krow_q;
        kernel_d     = kernel_q;
        kvalid_d     = 1'b0;
        img_len_d    = img_len_q;
        wsel_d       = wsel_q;
        waddr_d      = waddr_q;
        we_d         = '0;
        maddr_d      = maddr_q;
        wdata_d      = wdata_q;
        start_pend_d = 1'b0;
        start_d      = start_pend_q;
        led_d        = led_q;
        rsel_d       = rsel_q;
        raddr_d      = raddr_q;
        rdata_d      = (state_q == READ) ? i_rd_data : rdata_q;
        do_cmd       = 1'b0;

        case (state_q)
            IDLE: do_cmd = 1'b1;
            RUN: begin
                if (i_conv_done && !start_q && !start_pend_q) begin
                    state_d = READY;
                    led_d   = 1'b1;
                end
            end
            READY: begin
                if (ctrl == 3'b011) begin
                    state_d = READ;
                    rsel_d  = '0;
                    raddr_d = '0;
                end else if (ctrl == 3'b010 || ctrl == 3'b000) begin
                    state_d = IDLE;
                    led_d   = 1'b0;
                    do_cmd  = 1'b1;
                end
            end
            READ: begin
                if (ctrl != 3'b011) begin
                    state_d = READY;
                end else if (evt) begin
                    if (raddr_q == img_len_q - ADDR_W'(2)) begin
                        raddr_d = '0;
                        if (rsel_q == RS_W'(N-1)) begin
                            rsel_d  = '0;
                            state_d = IDLE;
                            led_d   = 1'b0;
                        end else begin
                            rsel_d = rsel_q + RS_W'(1);
                        end
                    end else begin
                        raddr_d = raddr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_cmd) begin
            if (ctrl == 3'b000) begin
                krow_d = krow_eff;
                if (evt) begin
                    kernel_d[krow_eff] = data;
                    kvalid_d           = (krow_eff == 2'd2);
                    krow_d             = (krow_eff == 2'd2) ? 2'd0 : krow_eff + 2'd1;
                end
            end
            if (ctrl == 3'b001 && state_q == IDLE) begin
                img_len_d = data[ADDR_W-1:0];
            end
            if (evt && (ctrl == 3'b010 || (ctrl == 3'b100 && state_q == IDLE))) begin
                we_d    = {{(N+1){1'b0}}, 1'b1} << wsel_q;
                maddr_d = waddr_q;
                wdata_d = data[PIX_W-1:0];
                if (waddr_q == img_len_q) begin
                    waddr_d = '0;
                    wsel_d  = (wsel_q == WS_W'(N+1)) ? '0 : wsel_q + WS_W'(1);
                end else begin
                    waddr_d = waddr_q + ADDR_W'(1);
                end
                if (ctrl == 3'b100) begin
                    start_pend_d = 1'b1;
                    state_d      = RUN;
                end
            end
        end

        if (soft_rst) begin
            state_d      = IDLE;
            krow_d       = '0;
            kernel_d     = '0;
            kvalid_d     = 1'b0;
            img_len_d    = '0;
            wsel_d       = '0;
            waddr_d      = '0;
            we_d         = '0;
            maddr_d      = '0;
            wdata_d      = '0;
            start_pend_d = 1'b0;
            start_d      = 1'b0;
            led_d        = 1'b0;
            rsel_d       = '0;
            raddr_d      = '0;
            rdata_d      = '0;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q      <= IDLE;
            valid_prev_q <= 1'b0;
            ctrl_prev_q  <= '0;
            krow_q       <= '0;
            kernel_q     <= '0;
            kvalid_q     <= 1'b0;
            img_len_q    <= '0;
            wsel_q       <= '0;
            waddr_q      <= '0;
            we_q         <= '0;
            maddr_q      <= '0;
            wdata_q      <= '0;
            start_pend_q <= 1'b0;
            start_q      <= 1'b0;
            led_q        <= 1'b0;
            rsel_q       <= '0;
            raddr_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            valid_prev_q <= valid_prev_d;
            ctrl_prev_q  <= ctrl_prev_d;
            krow_q       <= krow_d;
            kernel_q     <= kernel_d;
            kvalid_q     <= kvalid_d;
            img_len_q    <= img_len_d;
            wsel_q       <= wsel_d;
            waddr_q      <= waddr_d;
            we_q         <= we_d;
            maddr_q      <= maddr_d;
            wdata_q      <= wdata_d;
            start_pend_q <= start_pend_d;
            start_q      <= start_d;
            led_q        <= led_d;
            rsel_q       <= rsel_d;
            raddr_q      <= raddr_d;
            rdata_q      <= rdata_d;
        end
    end

    assign o_gpio         = {{(GPIO_D-RES_W){1'b0}}, rdata_q};
    assign o_led          = led_q;
    assign o_kernel       = kernel_q;
    assign o_kernel_valid = kvalid_q;
    assign o_img_len      = img_len_q;
    assign o_mem_we       = we_q;
    assign o_mem_addr     = maddr_q;
    assign o_mem_wdata    = wdata_q;
    assign o_start        = start_q;
    assign o_rd_sel       = rsel_q;
    assign o_rd_addr      = raddr_q;
endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// Directed-plus-random bench for gpio_cmd_ctrl; a counter-based model predicts
// kernel rows, column-memory write targets and read-back order.
module tb_gpio_cmd_ctrl;
    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio;
    logic        conv_done;
    logic [12:0] rd_data;
    logic [31:0] o_gpio;
    logic        o_led;
    logic [71:0] o_kernel;
    logic        o_kernel_valid;
    logic [9:0]  o_img_len;
    logic [3:0]  o_mem_we;
    logic [9:0]  o_mem_addr;
    logic [7:0]  o_mem_wdata;
    logic        o_start;
    logic [0:0]  o_rd_sel;
    logic [9:0]  o_rd_addr;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    int krow = 0;
    int len_m;
    logic [23:0] kmod [3];
    logic [2:0]  cur_c;
    logic [12:0] res_mem [2][1024];

    always #5 clk = ~clk;

    gpio_cmd_ctrl #(.N(N), .ADDR_W(10), .PIX_W(8), .RES_W(13), .GPIO_D(32)) dut (
        .i_CLK(clk), .i_RST(rst), .i_gpio(gpio), .o_gpio(o_gpio), .o_led(o_led),
        .o_kernel(o_kernel), .o_kernel_valid(o_kernel_valid), .o_img_len(o_img_len),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_start(o_start), .i_conv_done(conv_done), .o_rd_sel(o_rd_sel),
        .o_rd_addr(o_rd_addr), .i_rd_data(rd_data)
    );

    // Result memories with one cycle of read latency.
    always @(posedge clk) rd_data <= res_mem[o_rd_sel][o_rd_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic v, input logic [23:0] d, input logic s);
        cur_c = c;
        gpio  = {c, v, 3'b000, d, s};
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gpio"}, o_gpio, 0);
        chk({tag, "_led"}, o_led, 0);
        chk({tag, "_kernel"}, o_kernel, 0);
        chk({tag, "_kvalid"}, o_kernel_valid, 0);
        chk({tag, "_len"}, o_img_len, 0);
        chk({tag, "_we"}, o_mem_we, 0);
        chk({tag, "_maddr"}, o_mem_addr, 0);
        chk({tag, "_wdata"}, o_mem_wdata, 0);
        chk({tag, "_start"}, o_start, 0);
        chk({tag, "_rdsel"}, o_rd_sel, 0);
        chk({tag, "_rdaddr"}, o_rd_addr, 0);
    endtask

    task automatic fill_results();
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 1024; a++)
                res_mem[s][a] = 13'($urandom);
    endtask

    task automatic model_clear();
        wr_count = 0;
        krow     = 0;
        for (int r = 0; r < 3; r++) kmod[r] = '0;
    endtask

    task automatic kev(input logic [23:0] d);
        if (cur_c != 3'b000) krow = 0;
        drive(3'b000, 1'b1, d, 1'b0);
        tick();
        kmod[krow] = d;
        $display("kernel row%0d <= %06h", krow, d);
        chk("kernel", o_kernel, {kmod[2], kmod[1], kmod[0]});
        chk("kvalid", o_kernel_valid, (krow == 2));
        krow = (krow + 1) % 3;
        drive(3'b000, 1'b0, d, 1'b0);
        tick();
        chk("kvalid_off", o_kernel_valid, 0);
    endtask

    task automatic pix(input logic [2:0] c, input logic [23:0] d, input bit hold);
        int sel;
        int addr;
        sel  = (wr_count / (len_m + 1)) % (N + 2);
        addr = wr_count % (len_m + 1);
        drive(c, 1'b1, d, 1'b0);
        tick();
        $display("pix ctrl=%0d sel=%0d addr=%0d data=%02h", c, sel, addr, d[7:0]);
        chk("we", o_mem_we, 4'b0001 << sel);
        chk("waddr", o_mem_addr, addr);
        chk("wdata", o_mem_wdata, d[7:0]);
        chk("start_early", o_start, 0);
        wr_count++;
        if (hold) begin
            repeat (2) begin
                tick();
                chk("we_held", o_mem_we, 0);
            end
        end
        drive(c, 1'b0, d, 1'b0);
        tick();
        chk("we_off", o_mem_we, 0);
    endtask

    task automatic run_to_ready();
        chk("start", o_start, 1);
        conv_done = 1'b1;
        drive(3'b111, 1'b0, 0, 1'b0);
        tick();
        conv_done = 1'b0;
        chk("start_off", o_start, 0);
        chk("done_with_start", o_led, 0);
        for (int j = 0; j < 2; j++) begin
            drive(3'b010, 1'b1, 24'($urandom), 1'b0);
            tick();
            chk("run_we", o_mem_we, 0);
            drive(3'b111, 1'b0, 0, 1'b0);
            tick();
        end
        chk("run_led", o_led, 0);
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        $display("conv_done -> ready");
        chk("led_ready", o_led, 1);
    endtask

    task automatic read_batch(input int len);
        int tot;
        int sel;
        int a;
        tot = N * (len - 1);
        drive(3'b011, 1'b0, 0, 1'b0);
        tick();
        chk("read_led", o_led, 1);
        chk("read_addr0", o_rd_addr, 0);
        chk("read_sel0", o_rd_sel, 0);
        tick();
        tick();
        drive(3'b011, 1'b1, 0, 1'b0);
        tick();
        drive(3'b011, 1'b0, 0, 1'b0);
        chk("rd_adv", o_rd_addr, 1);
        drive(3'b111, 1'b0, 0, 1'b0);
        tick();
        chk("read_to_ready", o_led, 1);
        drive(3'b011, 1'b0, 0, 1'b0);
        tick();
        chk("reenter_addr", o_rd_addr, 0);
        for (int k = 0; k < tot; k++) begin
            tick();
            tick();
            sel = k / (len - 1);
            a   = k % (len - 1);
            $display("read #%0d sel=%0d addr=%0d data=%04h", k, sel, a, o_gpio[12:0]);
            chk("rd_sel", o_rd_sel, sel);
            chk("rd_addr", o_rd_addr, a);
            chk("rd_gpio", o_gpio, {19'b0, res_mem[sel][a]});
            chk("rd_led", o_led, 1);
            drive(3'b011, 1'b1, 0, 1'b0);
            tick();
            drive(3'b011, 1'b0, 0, 1'b0);
        end
        chk("led_off", o_led, 0);
        tick();
        tick();
        chk("gpio_hold", o_gpio, {19'b0, res_mem[N-1][len-2]});
    endtask

    initial begin
        int nw;
        rst       = 1'b1;
        conv_done = 1'b0;
        drive(3'b000, 1'b0, 0, 1'b0);
        fill_results();
        model_clear();
        len_m = 0;
        #1;
        chk_zero("arst");
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_zero("post_rst");

        kev(24'h002000);
        kev(24'h208020);
        kev(24'h002000);
        chk("kernel_const", o_kernel, 72'h002000_208020_002000);
        kev(24'($urandom));

        drive(3'b001, 1'b0, 24'd15, 1'b0);
        tick();
        len_m = 15;
        chk("img_len", o_img_len, 15);
        for (int i = 0; i < 5; i++) pix(3'b010, 24'(i), 1'b0);
        drive(3'b010, 1'b0, 0, 1'b1);
        tick();
        drive(3'b010, 1'b0, 0, 1'b0);
        $display("soft reset");
        chk_zero("srst");
        model_clear();

        drive(3'b001, 1'b0, 24'd15, 1'b0);
        tick();
        chk("img_len2", o_img_len, 15);
        for (int i = 0; i < 64; i++) pix((i == 63) ? 3'b100 : 3'b010, 24'(i), (i == 10));
        run_to_ready();
        read_batch(15);

        for (int i = 0; i < 32; i++) pix((i == 31) ? 3'b100 : 3'b010, 24'($urandom), 1'b0);
        run_to_ready();
        kev(24'($urandom));
        chk("ready_exit_led", o_led, 0);

        drive(3'b111, 1'b0, 0, 1'b1);
        tick();
        drive(3'b111, 1'b0, 0, 1'b0);
        model_clear();
        chk("srst_len", o_img_len, 0);
        len_m = $urandom_range(3, 40);
        drive(3'b001, 1'b0, 24'(len_m), 1'b0);
        tick();
        chk("img_len3", o_img_len, len_m);
        fill_results();
        nw = $urandom_range(1, 4 * (len_m + 1) + 5);
        for (int i = 0; i < nw; i++) pix((i == nw - 1) ? 3'b100 : 3'b010, 24'($urandom), 1'b0);
        run_to_ready();
        read_batch(len_m);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
